// File: rtl/text_pkg.sv
// Shared constants, ASCII codes and FSM encoding for the text-window buffer controller.
package text_pkg;

  localparam int COLS   = 32;
  localparam int ROWS   = 4;
  localparam int CELLS  = COLS * ROWS;
  localparam int CHAR_W = 7;

  localparam logic [CHAR_W-1:0] SPACE = 7'h20;
  localparam logic [CHAR_W-1:0] BS    = 7'h08;
  localparam logic [CHAR_W-1:0] LF    = 7'h0A;
  localparam logic [CHAR_W-1:0] CR    = 7'h0D;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SCROLL    = 2'd2,
    ST_CLEAR_ROW = 2'd3
  } state_t;

  function automatic logic is_printable(input logic [CHAR_W-1:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Character store: one synchronous write port, two synchronous read-first read ports.
module text_buffer_ram
  import text_pkg::*;
#(
  parameter int DEPTH = CELLS,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = CHAR_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_disp_addr,
  output logic [DW-1:0] o_disp_data,
  input  logic [AW-1:0] i_scroll_addr,
  output logic [DW-1:0] o_scroll_data
);

  // NOTE: the array has no reset; the controller's CLEAR pass initialises it, which keeps it mappable to block RAM.
  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: non-blocking assignments make a same-edge read of the written cell return the old value (read-first).
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_disp_data   <= r_mem[i_disp_addr];
    o_scroll_data <= r_mem[i_scroll_addr];
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// 32x4 text window controller: cursor/backspace/newline/scroll sequencing plus the pixel-to-cell display read.
module text_buffer_ctrl #(
  parameter int COLS = 32,
  parameter int ROWS = 4,
  parameter int X0   = 192,
  parameter int Y0   = 208
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    char_valid,
  input  logic [6:0]              char_data,
  output logic                    char_ready,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  output logic [6:0]              ascii_code,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  import text_pkg::state_t;
  import text_pkg::ST_CLEAR;
  import text_pkg::ST_IDLE;
  import text_pkg::ST_SCROLL;
  import text_pkg::ST_CLEAR_ROW;
  import text_pkg::SPACE;
  import text_pkg::BS;
  import text_pkg::LF;
  import text_pkg::CR;
  import text_pkg::is_printable;

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW;
  localparam int CELLS = COLS * ROWS;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_char_ready;
  logic          r_busy;
  logic          r_inside;

  logic          w_accept;
  logic          w_printable;
  logic          w_line_end;
  logic          w_last_row;
  logic [AW-1:0] w_cur_addr;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [6:0]    w_wdata;
  logic [AW-1:0] w_scroll_raddr;
  logic [6:0]    w_scroll_rdata;
  logic [CW-1:0] w_disp_col;
  logic [RW-1:0] w_disp_row;
  logic          w_inside;
  logic [6:0]    w_disp_rdata;

  assign w_accept    = char_valid && r_char_ready;
  assign w_printable = is_printable(char_data);
  assign w_line_end  = (char_data == LF) || (char_data == CR) ||
                       (w_printable && (r_col == CW'(COLS - 1)));
  assign w_last_row  = (r_row == RW'(ROWS - 1));
  // COLS is a power of two, so row*COLS+col is a plain concatenation.
  assign w_cur_addr     = {r_row, r_col};
  assign w_scroll_raddr = r_cnt + AW'(COLS);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_cur_addr;
    w_wdata = SPACE;
    if (!reset) begin
      case (r_state)
        ST_CLEAR: begin
          w_we    = 1'b1;
          w_waddr = r_cnt;
        end
        ST_IDLE: begin
          if (w_accept && w_printable) begin
            w_we    = 1'b1;
            w_wdata = char_data;
          end else if (w_accept && (char_data == BS) && (w_cur_addr != '0)) begin
            w_we    = 1'b1;
            w_waddr = w_cur_addr - AW'(1);
          end
        end
        ST_SCROLL: begin
          // Read of cell cnt+COLS issued last cycle lands in cell cnt-1 now.
          if (r_cnt != '0) begin
            w_we    = 1'b1;
            w_waddr = r_cnt - AW'(1);
            w_wdata = w_scroll_rdata;
          end
        end
        ST_CLEAR_ROW: begin
          w_we    = 1'b1;
          w_waddr = AW'(CELLS - COLS) + r_cnt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_char_ready <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(CELLS - 1)) begin
            r_state      <= ST_IDLE;
            r_char_ready <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            if (w_line_end) begin
              r_col <= '0;
              if (w_last_row) begin
                r_state      <= ST_SCROLL;
                r_cnt        <= '0;
                r_char_ready <= 1'b0;
                r_busy       <= 1'b1;
              end else begin
                r_row <= r_row + RW'(1);
              end
            end else if (w_printable) begin
              r_col <= r_col + CW'(1);
            end else if ((char_data == BS) && (w_cur_addr != '0)) begin
              {r_row, r_col} <= w_cur_addr - AW'(1);
            end
          end
        end
        ST_SCROLL: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(CELLS - COLS)) begin
            r_state <= ST_CLEAR_ROW;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR_ROW: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(COLS - 1)) begin
            r_state      <= ST_IDLE;
            r_char_ready <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Low bits of (x/8 - X0/8) and (y/16 - Y0/16); the window test rejects everything else.
  assign w_disp_col = x[CW+2:3] - CW'(X0 / 8);
  assign w_disp_row = y[RW+3:4] - RW'(Y0 / 16);
  assign w_inside   = (x >= 10'(X0)) && (x < 10'(X0 + COLS * 8)) &&
                      (y >= 10'(Y0)) && (y < 10'(Y0 + ROWS * 16));

  always_ff @(posedge clk) begin
    if (reset) r_inside <= 1'b0;
    else       r_inside <= w_inside;
  end

  text_buffer_ram #(
    .DEPTH(CELLS),
    .AW   (AW),
    .DW   (7)
  ) u_ram (
    .clk          (clk),
    .i_we         (w_we),
    .i_waddr      (w_waddr),
    .i_wdata      (w_wdata),
    .i_disp_addr  ({w_disp_row, w_disp_col}),
    .o_disp_data  (w_disp_rdata),
    .i_scroll_addr(w_scroll_raddr),
    .o_scroll_data(w_scroll_rdata)
  );

  assign ascii_code = r_inside ? w_disp_rdata : SPACE;
  assign char_ready = r_char_ready;
  assign busy       = r_busy;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Randomised bench for text_buffer_ctrl against a row/column screen model with immediate scrolling.
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic [6:0] char_data;
  logic       char_ready;
  logic [9:0] x;
  logic [9:0] y;
  logic [6:0] ascii_code;
  logic [4:0] cursor_col;
  logic [1:0] cursor_row;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int m_mem [128];
  int m_row;
  int m_col;

  always #5 clk = ~clk;

  text_buffer_ctrl #(
    .COLS(32),
    .ROWS(4),
    .X0  (192),
    .Y0  (208)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .x         (x),
    .y         (y),
    .ascii_code(ascii_code),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Screen model: a 4x32 grid of characters and a cursor, scrolled as soon as a line overflows.
  function automatic void m_clear();
    for (int i = 0; i < 128; i++) m_mem[i] = 32'h20;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void m_scroll();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 32; c++) m_mem[r*32 + c] = m_mem[(r+1)*32 + c];
    for (int c = 0; c < 32; c++) m_mem[96 + c] = 32'h20;
    m_row = 3;
  endfunction

  function automatic void m_newline();
    m_col = 0;
    if (m_row == 3) m_scroll();
    else            m_row++;
  endfunction

  function automatic void m_apply(input int c);
    if (c >= 32'h20 && c <= 32'h7E) begin
      m_mem[m_row*32 + m_col] = c;
      if (m_col == 31) m_newline();
      else             m_col++;
    end else if (c == 32'h0A || c == 32'h0D) begin
      m_newline();
    end else if (c == 32'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row*32 + m_col] = 32'h20;
      end else if (m_row > 0) begin
        m_row--;
        m_col = 31;
        m_mem[m_row*32 + m_col] = 32'h20;
      end
    end
  endfunction

  // All tasks start and end on a falling edge.
  task automatic do_reset();
    int n;
    reset      = 1'b1;
    char_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    check("rst_ready", char_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);
    check("rst_ascii", ascii_code, 32'h20);
    n = 0;
    while (!char_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("clear_len", n, 128);
    check("clear_busy_done", busy, 0);
  endtask

  task automatic send(input logic [6:0] c, output int waited);
    char_valid = 1'b1;
    char_data  = c;
    waited     = 0;
    while (!char_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", char_ready, 1);
    @(negedge clk);
    char_valid = 1'b0;
    m_apply(int'(c));
    check($sformatf("cur_col_after_%0h", c), cursor_col, m_col);
    check($sformatf("cur_row_after_%0h", c), cursor_row, m_row);
  endtask

  task automatic send_n(input logic [6:0] c, input int count);
    int w;
    for (int i = 0; i < count; i++) send(c, w);
  endtask

  task automatic read_xy(input int px, input int py, output logic [6:0] val);
    x = 10'(px);
    y = 10'(py);
    @(negedge clk);
    val = ascii_code;
  endtask

  task automatic read_cell(input int idx, output logic [6:0] val);
    read_xy(192 + (idx % 32) * 8 + int'($urandom_range(0, 7)),
            208 + (idx / 32) * 16 + int'($urandom_range(0, 15)), val);
  endtask

  task automatic scan(input string tag);
    logic [6:0] v;
    for (int i = 0; i < 128; i++) begin
      read_cell(i, v);
      check($sformatf("%s_cell%0d", tag, i), v, m_mem[i]);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] v;
    int         w;
    int         n;
    int         r;
    logic [6:0] c;
    int         outside [6][2] = '{'{191, 208}, '{448, 208}, '{192, 207},
                                   '{192, 272}, '{704, 220}, '{1023, 1023}};

    reset      = 1'b1;
    char_valid = 1'b0;
    char_data  = '0;
    x          = '0;
    y          = '0;
    @(negedge clk);

    // Reset clear and window boundaries.
    do_reset();
    scan("reset_clear");
    send_n(7'h41, 1);
    read_xy(192, 208, v);
    check("corner_first_cell", v, 32'h41);
    for (int i = 0; i < 6; i++) begin
      read_xy(outside[i][0], outside[i][1], v);
      check($sformatf("outside_%0d_%0d", outside[i][0], outside[i][1]), v, 32'h20);
    end

    // Basic write.
    do_reset();
    send_n(7'h41, 1);
    send_n(7'h42, 1);
    check("ab_col", cursor_col, 2);
    check("ab_row", cursor_row, 0);
    read_xy(200, 210, v);
    check("pixel_200_210", v, 32'h42);
    scan("basic");

    // Backspace at home, wrap, backspace across a row boundary.
    do_reset();
    send_n(7'h08, 1);
    check("bs_home_col", cursor_col, 0);
    check("bs_home_row", cursor_row, 0);
    send_n(7'h78, 32);
    check("wrap_col", cursor_col, 0);
    check("wrap_row", cursor_row, 1);
    send_n(7'h08, 1);
    check("bs_wrap_col", cursor_col, 31);
    check("bs_wrap_row", cursor_row, 0);
    read_cell(31, v);
    check("bs_cell31", v, 32'h20);
    scan("wrap");

    // Scroll via line feed from the last row.
    do_reset();
    send_n(7'h30, 32);
    send_n(7'h31, 32);
    send_n(7'h32, 32);
    send_n(7'h33, 31);
    send_n(7'h0A, 1);
    n = 0;
    while (busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("scroll_busy_len", n, 129);
    check("scroll_col", cursor_col, 0);
    check("scroll_row", cursor_row, 3);
    read_cell(5, v);
    check("scroll_row0", v, 32'h31);
    read_cell(96, v);
    check("scroll_row3", v, 32'h20);
    scan("scroll");

    // Back-pressure: a printable at (3,31) starts a scroll while 'Z' is held.
    send_n(7'h71, 31);
    send_n(7'h71, 1);
    send(7'h5A, w);
    check("bp_wait", w, 129);
    read_cell(96, v);
    check("bp_z_cell96", v, 32'h5A);
    send_n(7'h07, 1);
    check("bel_col", cursor_col, 1);
    check("bel_row", cursor_row, 3);
    scan("backpressure");

    // Reset in the middle of a scroll.
    send_n(7'h0D, 1);
    check("mid_busy", busy, 1);
    repeat (40) @(negedge clk);
    do_reset();
    scan("mid_scroll_reset");

    // Random character stream.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      c = 7'($urandom_range(32'h20, 32'h7E));
      else if (r < 78) c = 7'h0A;
      else if (r < 82) c = 7'h0D;
      else if (r < 92) c = 7'h08;
      else if (r < 97) c = 7'($urandom_range(0, 31));
      else             c = 7'h7F;
      send(c, w);
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
      if (i % 100 == 99) begin
        wait_idle();
        scan($sformatf("random_%0d", i));
      end
    end
    wait_idle();
    scan("random_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
